// File: rtl/step_ctrl.sv
// Execution controller for the pipelined CPU core. It synchronises and debounces the step button,
// edge-detects start, and runs the IDLE/RUN/STEP/HALTED sequencer that gates the core clock enable.
module step_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int DEB_W      = 20,
  parameter int TICK_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              button,
  input  logic              enable,
  input  logic              start,
  input  logic              halt,
  output logic              cpu_ce,
  output logic              cpu_start,
  output logic [TICK_W-1:0] ticks,
  output logic [1:0]        state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_STEP   = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             btn_sync_p0, btn_sync_p1;
  logic             start_sync_p0, start_sync_p1, start_prev;
  logic             deb_lvl, deb_lvl_prev;
  logic [DEB_W-1:0] deb_cnt;
  logic             btn_press, start_pulse, leave_idle, step_ce;
  logic [1:0]       state_nxt;

  // Stage p0/p1: two-flop synchronisers for the asynchronous board inputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_sync_p0   <= 1'b0;
      btn_sync_p1   <= 1'b0;
      start_sync_p0 <= 1'b0;
      start_sync_p1 <= 1'b0;
      start_prev    <= 1'b0;
    end else begin
      btn_sync_p0   <= button;
      btn_sync_p1   <= btn_sync_p0;
      start_sync_p0 <= start;
      start_sync_p1 <= start_sync_p0;
      start_prev    <= start_sync_p1;
    end
  end

  // Debounce: a new level is only accepted after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_lvl      <= 1'b0;
      deb_lvl_prev <= 1'b0;
      deb_cnt      <= '0;
    end else begin
      deb_lvl_prev <= deb_lvl;
      if (btn_sync_p1 == deb_lvl) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_lvl <= btn_sync_p1;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  assign btn_press   = deb_lvl & ~deb_lvl_prev;
  assign start_pulse = start_sync_p1 & ~start_prev;
  assign leave_idle  = ((state == S_IDLE) || (state == S_HALTED)) && start_pulse;

  // halt outranks an enable change; start is only honoured from IDLE/HALTED
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_HALTED: if (start_pulse) state_nxt = enable ? S_RUN : S_STEP;
      S_RUN:            if (halt) state_nxt = S_HALTED;
                        else if (!enable) state_nxt = S_STEP;
      S_STEP:           if (halt) state_nxt = S_HALTED;
                        else if (enable) state_nxt = S_RUN;
      default:          state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cpu_start <= 1'b0;
      step_ce   <= 1'b0;
      ticks     <= '0;
    end else begin
      state     <= state_nxt;
      cpu_start <= leave_idle;
      step_ce   <= (state == S_STEP) && (state_nxt == S_STEP) && btn_press;
      if (leave_idle)
        ticks <= '0;
      else if (cpu_ce)
        ticks <= ticks + TICK_W'(1);
    end
  end

  assign cpu_ce = (state == S_RUN) | step_ce;

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl: expected values are queued as stimulus is applied
// and compared against the DUT outputs at each sampling point.
module tb_step_ctrl;

  localparam int TICK_W = 8;

  logic              clk = 1'b0;
  logic              reset, button, enable, start, halt;
  logic              cpu_ce, cpu_start;
  logic [TICK_W-1:0] ticks;
  logic [1:0]        state;

  step_ctrl #(.DEB_CYCLES(16), .DEB_W(20), .TICK_W(TICK_W)) dut (
    .clk(clk), .reset(reset), .button(button), .enable(enable), .start(start),
    .halt(halt), .cpu_ce(cpu_ce), .cpu_start(cpu_start), .ticks(ticks), .state(state)
  );

  always #5 clk = ~clk;

  localparam int SEL_STATE = 0, SEL_CE = 1, SEL_START = 2, SEL_TICKS = 3;
  localparam int SEL_RISES = 4, SEL_CECYC = 5, SEL_STARTS = 6;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  int   rises = 0, ce_cycles = 0, starts = 0;
  logic ce_prev = 1'b0;

  always @(negedge clk) begin
    if (cpu_ce === 1'b1) ce_cycles++;
    if (cpu_ce === 1'b1 && ce_prev !== 1'b1) rises++;
    if (cpu_start === 1'b1) starts++;
    ce_prev = cpu_ce;
  end

  function automatic logic [31:0] observe(int sel);
    case (sel)
      SEL_STATE:  return {30'b0, state};
      SEL_CE:     return {31'b0, cpu_ce};
      SEL_START:  return {31'b0, cpu_start};
      SEL_TICKS:  return {{(32-TICK_W){1'b0}}, ticks};
      SEL_RISES:  return rises;
      SEL_CECYC:  return ce_cycles;
      default:    return starts;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input int val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input string tag, input int exp_state);
    start = 1'b1;
    cyc(3);
    start = 1'b0;
    push({tag, "_state"}, SEL_STATE, exp_state);
    push({tag, "_cpu_start"}, SEL_START, 1);
    push({tag, "_ticks0"}, SEL_TICKS, 0);
    push({tag, "_ce"}, SEL_CE, (exp_state == 1) ? 1 : 0);
    check_sb();
    cyc(1);
    push({tag, "_cpu_start_end"}, SEL_START, 0);
    push({tag, "_ticks1"}, SEL_TICKS, (exp_state == 1) ? 1 : 0);
    check_sb();
  endtask

  task automatic press(input string tag, input int exp_ticks);
    button = 1'b1;
    cyc(18);
    push({tag, "_ce_before"}, SEL_CE, 0);
    check_sb();
    cyc(1);
    push({tag, "_ce_pulse"}, SEL_CE, 1);
    check_sb();
    cyc(1);
    push({tag, "_ce_after"}, SEL_CE, 0);
    push({tag, "_ticks"}, SEL_TICKS, exp_ticks);
    check_sb();
    cyc(20);
    button = 1'b0;
    cyc(40);
    push({tag, "_ce_idle"}, SEL_CE, 0);
    check_sb();
  endtask

  initial begin
    int rbase, cbase, sbase;
    reset = 1'b1; button = 1'b0; enable = 1'b1; start = 1'b0; halt = 1'b0;
    #3;
    push("rst_state", SEL_STATE, 0);
    push("rst_ce", SEL_CE, 0);
    push("rst_start", SEL_START, 0);
    push("rst_ticks", SEL_TICKS, 0);
    check_sb();
    cyc(2);
    reset = 1'b0;
    cyc(5);
    push("idle_state", SEL_STATE, 0);
    check_sb();

    // Free run
    do_start("run", 1);
    cyc(49);
    push("run_ticks50", SEL_TICKS, 50);
    push("run_ce", SEL_CE, 1);
    push("run_state", SEL_STATE, 1);
    check_sb();

    // Start while running is ignored
    sbase = starts;
    start = 1'b1;
    cyc(3);
    start = 1'b0;
    cyc(2);
    push("run_start_ign", SEL_STARTS, sbase);
    push("run_start_ticks", SEL_TICKS, 55);
    push("run_start_state", SEL_STATE, 1);
    check_sb();

    // Mode switching
    enable = 1'b0;
    cyc(1);
    push("sw_step_state", SEL_STATE, 2);
    push("sw_step_ce", SEL_CE, 0);
    push("sw_step_ticks", SEL_TICKS, 56);
    check_sb();
    cyc(4);
    push("sw_step_hold", SEL_TICKS, 56);
    check_sb();
    enable = 1'b1;
    cyc(1);
    push("sw_run_state", SEL_STATE, 1);
    push("sw_run_ce", SEL_CE, 1);
    push("sw_run_ticks", SEL_TICKS, 56);
    check_sb();
    cyc(1);
    push("sw_run_count", SEL_TICKS, 57);
    check_sb();

    // Halt together with enable falling: halt wins
    halt = 1'b1;
    enable = 1'b0;
    cyc(1);
    halt = 1'b0;
    push("hp_state", SEL_STATE, 3);
    push("hp_ce", SEL_CE, 0);
    push("hp_ticks", SEL_TICKS, 58);
    check_sb();
    halt = 1'b1;
    cyc(2);
    halt = 1'b0;
    cyc(3);
    push("hp_hold_state", SEL_STATE, 3);
    push("hp_hold_ticks", SEL_TICKS, 58);
    check_sb();

    // Halt at ticks=20 after a restart
    enable = 1'b1;
    do_start("rs", 1);
    cyc(19);
    push("halt_pre_ticks", SEL_TICKS, 20);
    check_sb();
    halt = 1'b1;
    cyc(1);
    halt = 1'b0;
    push("halt_state", SEL_STATE, 3);
    push("halt_ce", SEL_CE, 0);
    push("halt_ticks", SEL_TICKS, 21);
    check_sb();
    cyc(10);
    push("halt_frozen", SEL_TICKS, 21);
    push("halt_state2", SEL_STATE, 3);
    check_sb();

    // Single-step: three clean presses
    enable = 1'b0;
    do_start("step", 2);
    rbase = rises;
    cbase = ce_cycles;
    for (int i = 0; i < 3; i++) press($sformatf("press%0d", i), i + 1);
    push("step_pulses", SEL_RISES, rbase + 3);
    push("step_ce_cycles", SEL_CECYC, cbase + 3);
    push("step_ticks", SEL_TICKS, 3);
    push("step_state", SEL_STATE, 2);
    check_sb();

    // Bouncy press
    rbase = rises;
    cbase = ce_cycles;
    for (int i = 0; i < 10; i++) begin
      button = (i % 2 == 0);
      cyc(3);
    end
    push("bounce_no_pulse", SEL_RISES, rbase);
    check_sb();
    press("bounce", 4);
    push("bounce_pulses", SEL_RISES, rbase + 1);
    push("bounce_ce_cycles", SEL_CECYC, cbase + 1);
    check_sb();

    // Step -> run, then wrap of ticks
    enable = 1'b1;
    cyc(1);
    push("s2r_state", SEL_STATE, 1);
    push("s2r_ticks", SEL_TICKS, 4);
    check_sb();
    halt = 1'b1;
    cyc(1);
    halt = 1'b0;
    do_start("wrap", 1);
    cyc(254);
    push("wrap_max", SEL_TICKS, 255);
    check_sb();
    cyc(1);
    push("wrap_zero", SEL_TICKS, 0);
    check_sb();
    cyc(37);
    push("pre_rst_ticks", SEL_TICKS, 37);
    check_sb();

    // Asynchronous reset mid-run
    #2;
    reset = 1'b1;
    #1;
    push("arst_state", SEL_STATE, 0);
    push("arst_ce", SEL_CE, 0);
    push("arst_ticks", SEL_TICKS, 0);
    push("arst_start", SEL_START, 0);
    check_sb();
    @(posedge clk);
    #1;
    reset = 1'b0;
    sbase = starts;
    cyc(100);
    push("post_rst_state", SEL_STATE, 0);
    push("post_rst_ticks", SEL_TICKS, 0);
    push("post_rst_ce", SEL_CE, 0);
    push("post_rst_starts", SEL_STARTS, sbase);
    check_sb();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
